// File: rtl/popcount_rr_scheduler.sv
// popcount_rr_scheduler: round-robin front end that shares one pipelined
// population counter between N_REQ requesters. Issued requester IDs ride an
// in-order tag FIFO across the counter so each result is routed back to its
// issuer with a one-hot valid.
`timescale 1ns/1ps
module popcount_rr_scheduler #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WIDTH     = 1024,
  parameter int unsigned TAG_DEPTH = 8,
  localparam int unsigned COUNT_SIZE = $clog2(WIDTH)
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  input  logic                     en_i,
  input  logic [N_REQ*WIDTH-1:0]   req_data_i,
  input  logic [N_REQ-1:0]         req_val_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic [WIDTH-1:0]         pc_data_o,
  output logic                     pc_data_val_o,
  input  logic [COUNT_SIZE:0]      pc_data_i,
  input  logic                     pc_data_val_i,
  output logic [COUNT_SIZE:0]      res_data_o,
  output logic [N_REQ-1:0]         res_val_o,
  output logic                     idle_o,
  output logic                     err_o
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned RES_W = COUNT_SIZE + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e              state_q;
  logic                idle_q;
  logic                err_q;

  logic [IDX_W-1:0]    rr_ptr_q;
  logic [IDX_W-1:0]    rr_ptr_d;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_vld;
  logic [N_REQ-1:0]    grant_oh;
  logic [IDX_W:0]      cand;
  logic [WIDTH-1:0]    sel_data;

  logic [IDX_W-1:0]    tag_mem_q [TAG_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [IDX_W-1:0]    head_tag;

  logic [WIDTH-1:0]    pc_data_q;
  logic                pc_val_q;
  logic [RES_W-1:0]    res_data_q;
  logic [N_REQ-1:0]    res_val_q;

  // Occupancy flags; a same-cycle pop only frees a slot from the next cycle on.
  assign fifo_full  = (count_q == CNT_W'(TAG_DEPTH));
  assign fifo_empty = (count_q == CNT_W'(0));
  assign push       = grant_vld;
  assign pop        = pc_data_val_i & ~fifo_empty;
  assign head_tag   = tag_mem_q[rd_ptr_q];

  // Round-robin pick: first valid requester at or after the pointer.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    cand      = '0;
    rr_ptr_d  = rr_ptr_q;
    if (state_q == ST_RUN && !fifo_full) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
        if (cand >= (IDX_W+1)'(N_REQ)) begin
          cand = cand - (IDX_W+1)'(N_REQ);
        end
        if (!grant_vld && req_val_i[cand[IDX_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = cand[IDX_W-1:0];
        end
      end
    end
    if (grant_vld) begin
      grant_oh[grant_idx] = 1'b1;
      rr_ptr_d = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  // Select the granted requester's word for the counter.
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (grant_idx == IDX_W'(k)) begin
        sel_data = req_data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  // Arbitration pointer advances past each winner, holds when idle.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Tag storage: issuer ID of every word currently inside the counter.
  always_ff @(posedge clk_i) begin
    if (push) begin
      tag_mem_q[wr_ptr_q] <= grant_idx;
    end
  end

  // Tag FIFO pointers and occupancy; reset discards in-flight tags.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Issue register toward the counter; data holds between issues.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      pc_data_q <= '0;
      pc_val_q  <= 1'b0;
    end else begin
      pc_val_q <= grant_vld;
      if (grant_vld) begin
        pc_data_q <= sel_data;
      end
    end
  end

  // Return path: route each counter result to the head-of-FIFO issuer.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      res_data_q <= '0;
      res_val_q  <= '0;
    end else begin
      res_val_q <= pop ? (N_REQ'(1) << head_tag) : '0;
      if (pop) begin
        res_data_q <= pc_data_i;
      end
    end
  end

  // Sticky error: counter produced a result nobody is waiting for.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      err_q <= 1'b0;
    end else if (pc_data_val_i && fifo_empty) begin
      err_q <= 1'b1;
    end
  end

  // Control FSM: grants only in RUN, DRAIN waits for in-flight words.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= ST_IDLE;
      idle_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en_i) begin
            state_q <= ST_RUN;
            idle_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!en_i) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (en_i) begin
            state_q <= ST_RUN;
          end else if (fifo_empty && !pc_val_q) begin
            state_q <= ST_IDLE;
            idle_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o   = grant_oh;
  assign pc_data_o     = pc_data_q;
  assign pc_data_val_o = pc_val_q;
  assign res_data_o    = res_data_q;
  assign res_val_o     = res_val_q;
  assign idle_o        = idle_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_popcount_rr_scheduler.sv
// Bench for popcount_rr_scheduler: counter modelled as a 3-cycle popcount
// delay with stall/release/spurious controls, a per-cycle scoreboard, a
// table of arbitration vectors, directed corner cases and a random phase.
`timescale 1ns/1ps
module tb_popcount_rr_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 1024;
  localparam int unsigned D  = 8;
  localparam int unsigned RW = 11;

  logic              clk_i = 1'b0;
  logic              arstn_i = 1'b1;
  logic              en_i = 1'b0;
  logic [N*W-1:0]    req_data_i = '0;
  logic [N-1:0]      req_val_i = '0;
  logic [N-1:0]      req_ready_o;
  logic [W-1:0]      pc_data_o;
  logic              pc_data_val_o;
  logic [RW-1:0]     pc_data_i = '0;
  logic              pc_data_val_i = 1'b0;
  logic [RW-1:0]     res_data_o;
  logic [N-1:0]      res_val_o;
  logic              idle_o;
  logic              err_o;

  popcount_rr_scheduler #(.N_REQ(N), .WIDTH(W), .TAG_DEPTH(D)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .en_i(en_i),
    .req_data_i(req_data_i), .req_val_i(req_val_i), .req_ready_o(req_ready_o),
    .pc_data_o(pc_data_o), .pc_data_val_o(pc_data_val_o),
    .pc_data_i(pc_data_i), .pc_data_val_i(pc_data_val_i),
    .res_data_o(res_data_o), .res_val_o(res_val_o),
    .idle_o(idle_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // ---------------- counter model ----------------
  typedef struct {
    logic [RW-1:0] v;
    int            due;
  } cnt_t;

  cnt_t cq[$];
  int   cyc = 0;
  logic hold = 1'b0;
  int   rel_req = 0;
  int   rel_done = 0;
  int   spur_req = 0;
  int   spur_done = 0;

  always @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cq.delete();
      rel_done = rel_req;
      pc_data_val_i <= 1'b0;
      pc_data_i     <= '0;
    end else begin
      pc_data_val_i <= 1'b0;
      if (spur_done != spur_req) begin
        spur_done++;
        pc_data_val_i <= 1'b1;
        pc_data_i     <= RW'($urandom_range(0, 1024));
      end else if (cq.size() > 0 && cq[0].due <= cyc && (!hold || rel_done != rel_req)) begin
        if (hold) rel_done++;
        pc_data_val_i <= 1'b1;
        pc_data_i     <= cq[0].v;
        void'(cq.pop_front());
      end
      if (pc_data_val_o) cq.push_back('{v: RW'($countones(pc_data_o)), due: cyc + 2});
      cyc++;
    end
  end

  // ---------------- scoreboard state ----------------
  int            m_tags[$];
  logic [RW-1:0] m_res[$];
  int            m_ptr = 0;
  bit            m_run = 1'b0;
  bit            e_pcv = 1'b0;
  logic [W-1:0]  e_pcd = '0;
  logic [N-1:0]  e_rv = '0;
  logic [RW-1:0] e_rd = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Compare the ending cycle against the model, then advance the model.
  task automatic mon_sample();
    logic [N-1:0] eg;
    int gk;
    int tag;
    if (!arstn_i) begin
      m_tags.delete(); m_res.delete();
      m_ptr = 0; m_run = 1'b0; e_pcv = 1'b0; e_rv = '0; e_rd = '0;
      return;
    end
    eg = '0;
    gk = -1;
    if (m_run && m_tags.size() < D) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (gk < 0 && req_val_i[k]) gk = k;
      end
    end
    if (gk >= 0) eg[gk] = 1'b1;
    check("mon_ready", 64'(req_ready_o), 64'(eg));
    check("mon_pc_val", 64'(pc_data_val_o), 64'(e_pcv));
    if (e_pcv) begin
      checks++;
      if (pc_data_o !== e_pcd) begin
        errors++;
        $display("FAIL mon_pc_data: got low 0x%h, expected low 0x%h", pc_data_o[63:0], e_pcd[63:0]);
      end
    end
    check("mon_res_val", 64'(res_val_o), 64'(e_rv));
    if (e_rv != '0) check("mon_res_data", 64'(res_data_o), 64'(e_rd));
    if (pc_data_val_i && m_tags.size() > 0) begin
      tag = m_tags.pop_front();
      e_rv = '0;
      e_rv[tag] = 1'b1;
      e_rd = m_res.pop_front();
    end else begin
      e_rv = '0;
    end
    e_pcv = (gk >= 0);
    if (gk >= 0) begin
      e_pcd = req_data_i[gk*W +: W];
      m_tags.push_back(gk);
      m_res.push_back(RW'($countones(e_pcd)));
      m_ptr = (gk + 1) % N;
    end
    m_run = en_i;
  endtask

  task automatic step();
    @(posedge clk_i);
    mon_sample();
    #1;
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] w;
    for (int i = 0; i < W/32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic set_data(input bit zero);
    for (int k = 0; k < N; k++) req_data_i[k*W +: W] = zero ? '0 : rnd_word();
  endtask

  task automatic do_reset();
    arstn_i = 1'b0; en_i = 1'b0; req_val_i = '0; hold = 1'b0;
    #1;
    check("rst_ready", 64'(req_ready_o), 64'(0));
    check("rst_pc_val", 64'(pc_data_val_o), 64'(0));
    check("rst_res_val", 64'(res_val_o), 64'(0));
    check("rst_idle", 64'(idle_o), 64'(1));
    check("rst_err", 64'(err_o), 64'(0));
    step();
    step();
    arstn_i = 1'b1;
  endtask

  typedef struct {
    logic         en;
    logic [N-1:0] val;
    logic [N-1:0] exp;
    bit           zero;
  } row_t;

  row_t tbl[18];

  initial begin
    int nres;
    bit got;

    tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 1'b1};
    tbl[1]  = '{1'b1, 4'b1111, 4'b0001, 1'b1};
    tbl[2]  = '{1'b1, 4'b1111, 4'b0010, 1'b1};
    tbl[3]  = '{1'b1, 4'b1111, 4'b0100, 1'b1};
    tbl[4]  = '{1'b1, 4'b1111, 4'b1000, 1'b1};
    tbl[5]  = '{1'b1, 4'b1111, 4'b0001, 1'b1};
    tbl[6]  = '{1'b1, 4'b0101, 4'b0100, 1'b0};
    tbl[7]  = '{1'b1, 4'b0101, 4'b0001, 1'b0};
    tbl[8]  = '{1'b1, 4'b0000, 4'b0000, 1'b0};
    tbl[9]  = '{1'b1, 4'b1000, 4'b1000, 1'b0};
    tbl[10] = '{1'b1, 4'b0110, 4'b0010, 1'b0};
    tbl[11] = '{1'b1, 4'b0010, 4'b0010, 1'b0};
    tbl[12] = '{1'b1, 4'b1001, 4'b1000, 1'b0};
    tbl[13] = '{1'b0, 4'b1111, 4'b0001, 1'b0};
    tbl[14] = '{1'b0, 4'b1111, 4'b0000, 1'b0};
    tbl[15] = '{1'b1, 4'b1111, 4'b0000, 1'b0};
    tbl[16] = '{1'b1, 4'b0011, 4'b0010, 1'b0};
    tbl[17] = '{1'b1, 4'b0011, 4'b0001, 1'b0};

    #1;
    do_reset();

    // Single request from requester 2 with an all-ones word.
    en_i = 1'b1;
    step();
    set_data(1'b0);
    req_data_i[2*W +: W] = '1;
    req_val_i = 4'b0100;
    #1;
    check("t1_ready", 64'(req_ready_o), 64'(4'b0100));
    step();
    req_val_i = '0;
    check("t1_pc_val", 64'(pc_data_val_o), 64'(1));
    repeat (3) step();
    check("t1_res_early", 64'(res_val_o), 64'(0));
    step();
    check("t1_res_val", 64'(res_val_o), 64'(4'b0100));
    check("t1_res_data", 64'(res_data_o), 64'(1024));
    step();
    check("t1_res_after", 64'(res_val_o), 64'(0));
    repeat (4) step();

    // Arbitration vectors from reset, including zero-data rotation.
    do_reset();
    for (int r = 0; r < 18; r++) begin
      en_i = tbl[r].en;
      req_val_i = tbl[r].val;
      set_data(tbl[r].zero);
      #1;
      check($sformatf("tbl_ready[%0d]", r), 64'(req_ready_o), 64'(tbl[r].exp));
      step();
    end
    en_i = 1'b0; req_val_i = '0;
    repeat (12) step();
    check("tbl_idle", 64'(idle_o), 64'(1));

    // Counter stalled: FIFO fills, one return admits exactly one grant.
    do_reset();
    hold = 1'b1;
    en_i = 1'b1;
    step();
    req_val_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      set_data(1'b0);
      #1;
      check($sformatf("t3_fill[%0d]", i), 64'(req_ready_o), 64'(1 << (i % 4)));
      step();
    end
    check("t3_full0", 64'(req_ready_o), 64'(0));
    step();
    check("t3_full1", 64'(req_ready_o), 64'(0));
    rel_req++;
    step();
    check("t3_popcyc", 64'(req_ready_o), 64'(0));
    step();
    check("t3_onegrant", 64'(req_ready_o), 64'(4'b0001));
    step();
    check("t3_refull", 64'(req_ready_o), 64'(0));
    hold = 1'b0;
    req_val_i = '0;
    repeat (16) step();

    // Enable dropped with three words in flight.
    do_reset();
    en_i = 1'b1;
    step();
    req_val_i = 4'b1111;
    set_data(1'b0);
    step();
    set_data(1'b0);
    step();
    en_i = 1'b0;
    set_data(1'b0);
    #1;
    check("t4_last_grant", 64'(req_ready_o), 64'(4'b0100));
    step();
    nres = 0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      check("t4_no_grant", 64'(req_ready_o), 64'(0));
      if (res_val_o != '0) nres++;
      if (nres == 3) begin
        check("t4_idle_lo", 64'(idle_o), 64'(0));
        step();
        check("t4_idle_hi", 64'(idle_o), 64'(1));
        got = 1'b1;
      end else begin
        step();
      end
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL t4_drain: got %0d results, expected 3 within 20 cycles", nres);
    end
    req_val_i = '0;

    // Spurious counter output with nothing in flight.
    do_reset();
    check("t5_err_pre", 64'(err_o), 64'(0));
    spur_req++;
    step();
    check("t5_err_mid", 64'(err_o), 64'(0));
    step();
    check("t5_err", 64'(err_o), 64'(1));
    check("t5_res_val", 64'(res_val_o), 64'(0));
    repeat (3) step();
    check("t5_err_hold", 64'(err_o), 64'(1));
    check("t5_res_hold", 64'(res_val_o), 64'(0));

    // Asynchronous reset in the middle of a burst.
    do_reset();
    en_i = 1'b1;
    step();
    req_val_i = 4'b1111;
    set_data(1'b0);
    repeat (3) step();
    #2;
    arstn_i = 1'b0;
    #1;
    check("t6_ready", 64'(req_ready_o), 64'(0));
    check("t6_pc_val", 64'(pc_data_val_o), 64'(0));
    check("t6_pc_data", 64'(pc_data_o != '0), 64'(0));
    check("t6_res_val", 64'(res_val_o), 64'(0));
    check("t6_res_data", 64'(res_data_o), 64'(0));
    check("t6_idle", 64'(idle_o), 64'(1));
    step();
    arstn_i = 1'b1;
    en_i = 1'b1;
    req_val_i = 4'b1111;
    #1;
    check("t6_after_idle", 64'(req_ready_o), 64'(0));
    step();
    check("t6_restart0", 64'(req_ready_o), 64'(4'b0001));
    step();
    check("t6_restart1", 64'(req_ready_o), 64'(4'b0010));
    req_val_i = '0;
    repeat (8) step();
    check("t6_err", 64'(err_o), 64'(0));

    // Random traffic with random counter stalls and enable drops.
    do_reset();
    en_i = 1'b1;
    for (int c = 0; c < 400; c++) begin
      req_val_i = N'($urandom_range(0, 15));
      set_data(1'b0);
      hold = ($urandom_range(0, 9) < 3);
      en_i = ($urandom_range(0, 15) != 0);
      step();
    end
    en_i = 1'b0; req_val_i = '0; hold = 1'b0;
    for (int c = 0; c < 80 && !idle_o; c++) step();
    check("rand_idle", 64'(idle_o), 64'(1));
    check("rand_inflight", 64'(m_tags.size()), 64'(0));
    check("rand_err", 64'(err_o), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
